// File: rtl/riscv_mc_pkg.sv
// Shared types and encodings for the RV64 multicycle control unit.
// Holds the state enum, opcode/funct constants and the datapath mux and ALU encodings.
package riscv_mc_pkg;

    typedef enum logic [4:0] {
        S_RESET  = 5'd0,
        S_FETCH  = 5'd1,
        S_DECODE = 5'd2,
        S_EXEC_R = 5'd3,
        S_EXEC_I = 5'd4,
        S_WB_ALU = 5'd5,
        S_ADDR   = 5'd6,
        S_MEM_RD = 5'd7,
        S_WB_MEM = 5'd8,
        S_MEM_WR = 5'd9,
        S_BRANCH = 5'd10,
        S_LUI    = 5'd11,
        S_TRAP   = 5'd12
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_D   = 3'b011;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [6:0] F7_ADD = 7'b0000000;
    localparam logic [6:0] F7_SUB = 7'b0100000;

    localparam logic [2:0] ALU_PASS_A = 3'b000;
    localparam logic [2:0] ALU_ADD    = 3'b001;
    localparam logic [2:0] ALU_SUB    = 3'b010;
    localparam logic [2:0] ALU_PASS_B = 3'b111;

    localparam logic [1:0] SRC_B_REG  = 2'b00;
    localparam logic [1:0] SRC_B_FOUR = 2'b01;
    localparam logic [1:0] SRC_B_IMM  = 2'b10;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;

endpackage

// File: rtl/riscv_mc_decode.sv
// Combinational dispatch from the instruction fields to the state following DECODE.
// Any encoding outside the supported subset lands in TRAP.
module riscv_mc_decode
    import riscv_mc_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output state_t     dispatch
);

    always_comb begin
        dispatch = S_TRAP;
        case (opcode)
            OP_R: begin
                if (funct3 == F3_ADD && (funct7 == F7_ADD || funct7 == F7_SUB))
                    dispatch = S_EXEC_R;
            end
            OP_IMM: begin
                if (funct3 == F3_ADD)
                    dispatch = S_EXEC_I;
            end
            OP_LOAD, OP_STORE: begin
                if (funct3 == F3_D)
                    dispatch = S_ADDR;
            end
            OP_BRANCH: begin
                if (funct3 == F3_BEQ || funct3 == F3_BNE)
                    dispatch = S_BRANCH;
            end
            OP_LUI:  dispatch = S_LUI;
            default: dispatch = S_TRAP;
        endcase
    end

endmodule

// File: rtl/riscv_mc_ctrl.sv
// Multicycle control FSM for the RV64 datapath (add/sub/addi/ld/sd/beq/bne/lui).
// Optional retired-instruction counter enabled by defining RETIRE_CNT_EN.
module riscv_mc_ctrl
    import riscv_mc_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic             alu_zero,
    output logic             rst_dp,
    output logic             pc_wr,
    output logic             pc_src,
    output logic             ir_load,
    output logic             a_wr,
    output logic             b_wr,
    output logic             alu_out_wr,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_sel,
    output logic [2:0]       imm_type,
    output logic             mem_data_wr,
    output logic             mem_to_reg,
    output logic             reg_wr,
    output logic             halted,
    output logic [4:0]       state_dbg,
    output logic [CNT_W-1:0] retired_cnt
);

    localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LAT - 1);

    state_t           state, state_next, dispatch;
    logic [LAT_W-1:0] lat_cnt;
    logic             lat_last;

    riscv_mc_decode u_decode (
        .opcode   (opcode),
        .funct3   (funct3),
        .funct7   (funct7),
        .dispatch (dispatch)
    );

    assign lat_last  = (lat_cnt == '0);
    assign state_dbg = state;

    always_ff @(posedge CLK) begin
        if (RST) state <= S_RESET;
        else     state <= state_next;
    end

    // FETCH and MEM_RD are never re-entered directly, so a state change reloads the count.
    always_ff @(posedge CLK) begin
        if (RST)                       lat_cnt <= '0;
        else if (state_next != state)  lat_cnt <= LAT_INIT;
        else if (!lat_last)            lat_cnt <= lat_cnt - 1'b1;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_RESET:  state_next = S_FETCH;
            S_FETCH:  if (lat_last) state_next = S_DECODE;
            S_DECODE: state_next = dispatch;
            S_EXEC_R: state_next = S_WB_ALU;
            S_EXEC_I: state_next = S_WB_ALU;
            S_ADDR:   state_next = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: if (lat_last) state_next = S_WB_MEM;
            S_WB_ALU, S_WB_MEM, S_MEM_WR, S_BRANCH, S_LUI:
                      state_next = S_FETCH;
            S_TRAP:   state_next = S_TRAP;
            default:  state_next = S_RESET;
        endcase
    end

    always_comb begin
        rst_dp      = 1'b0;
        pc_wr       = 1'b0;
        pc_src      = 1'b0;
        ir_load     = 1'b0;
        a_wr        = 1'b0;
        b_wr        = 1'b0;
        alu_out_wr  = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = SRC_B_REG;
        alu_sel     = ALU_PASS_A;
        imm_type    = IMM_I;
        mem_data_wr = 1'b0;
        mem_to_reg  = 1'b0;
        reg_wr      = 1'b0;
        halted      = 1'b0;
        case (state)
            S_RESET: rst_dp = 1'b1;
            S_FETCH: begin
                alu_src_b = SRC_B_FOUR;
                alu_sel   = ALU_ADD;
                if (lat_last) begin
                    ir_load = 1'b1;
                    pc_wr   = 1'b1;
                end
            end
            // Branch target is computed here, before the instruction class is known.
            S_DECODE: begin
                a_wr       = 1'b1;
                b_wr       = 1'b1;
                alu_src_b  = SRC_B_IMM;
                imm_type   = IMM_B;
                alu_sel    = ALU_ADD;
                alu_out_wr = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a  = 1'b1;
                alu_sel    = funct7[5] ? ALU_SUB : ALU_ADD;
                alu_out_wr = 1'b1;
            end
            S_EXEC_I: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRC_B_IMM;
                alu_sel    = ALU_ADD;
                alu_out_wr = 1'b1;
            end
            S_WB_ALU: reg_wr = 1'b1;
            S_ADDR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRC_B_IMM;
                imm_type   = (opcode == OP_STORE) ? IMM_S : IMM_I;
                alu_sel    = ALU_ADD;
                alu_out_wr = 1'b1;
            end
            S_WB_MEM: begin
                reg_wr     = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WR: mem_data_wr = 1'b1;
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_sel   = ALU_SUB;
                pc_src    = 1'b1;
                pc_wr     = funct3[0] ? !alu_zero : alu_zero;
            end
            S_LUI: begin
                alu_src_b = SRC_B_IMM;
                imm_type  = IMM_U;
                alu_sel   = ALU_PASS_B;
                reg_wr    = 1'b1;
            end
            S_TRAP:  halted = 1'b1;
            default: ;
        endcase
    end

`ifdef RETIRE_CNT_EN
    logic             retire;
    logic [CNT_W-1:0] cnt_q;

    assign retire = (state_next == S_FETCH) &&
                    (state inside {S_WB_ALU, S_WB_MEM, S_MEM_WR, S_BRANCH, S_LUI});

    always_ff @(posedge CLK) begin
        if (RST)         cnt_q <= '0;
        else if (retire) cnt_q <= cnt_q + CNT_W'(1);
    end

    assign retired_cnt = cnt_q;
`else
    assign retired_cnt = '0;
`endif

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// Bench for riscv_mc_ctrl: two instances (MEM_LAT=1 and 3) checked cycle by cycle
// against per-instruction expected output sequences built from the instruction rules.
module tb_riscv_mc_ctrl;
    import riscv_mc_pkg::*;

    typedef struct packed {
        logic [4:0] st;
        logic       rst_dp, pc_wr, pc_src, ir_load, a_wr, b_wr, alu_out_wr, alu_src_a;
        logic [1:0] src_b;
        logic [2:0] sel;
        logic [2:0] imm;
        logic       mem_wr, m2r, reg_wr, halted;
    } vec_t;

    typedef enum {K_ADD, K_SUB, K_ADDI, K_LD, K_SD, K_BEQ, K_BNE, K_LUI, K_ILL, K_ILL_F7} kind_t;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst      [2];
    logic [6:0]  opcode   [2];
    logic [2:0]  funct3   [2];
    logic [6:0]  funct7   [2];
    logic        alu_zero [2];

    logic        rst_dp_s [2], pc_wr_s [2], pc_src_s [2], ir_load_s [2];
    logic        a_wr_s [2], b_wr_s [2], alu_out_wr_s [2], alu_src_a_s [2];
    logic [1:0]  alu_src_b_s [2];
    logic [2:0]  alu_sel_s [2], imm_type_s [2];
    logic        mem_data_wr_s [2], mem_to_reg_s [2], reg_wr_s [2], halted_s [2];
    logic [4:0]  state_dbg_s [2];
    logic [31:0] retired_cnt_s [2];

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_dut
            riscv_mc_ctrl #(.MEM_LAT(g == 0 ? 1 : 3), .CNT_W(32)) u_dut (
                .CLK         (clk),
                .RST         (rst[g]),
                .opcode      (opcode[g]),
                .funct3      (funct3[g]),
                .funct7      (funct7[g]),
                .alu_zero    (alu_zero[g]),
                .rst_dp      (rst_dp_s[g]),
                .pc_wr       (pc_wr_s[g]),
                .pc_src      (pc_src_s[g]),
                .ir_load     (ir_load_s[g]),
                .a_wr        (a_wr_s[g]),
                .b_wr        (b_wr_s[g]),
                .alu_out_wr  (alu_out_wr_s[g]),
                .alu_src_a   (alu_src_a_s[g]),
                .alu_src_b   (alu_src_b_s[g]),
                .alu_sel     (alu_sel_s[g]),
                .imm_type    (imm_type_s[g]),
                .mem_data_wr (mem_data_wr_s[g]),
                .mem_to_reg  (mem_to_reg_s[g]),
                .reg_wr      (reg_wr_s[g]),
                .halted      (halted_s[g]),
                .state_dbg   (state_dbg_s[g]),
                .retired_cnt (retired_cnt_s[g])
            );
        end
    endgenerate

    // scoreboard
    int          checks = 0;
    int          failures = 0;
    logic [24:0] exp_q[$];
    int          exp_retired [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int lat_of(input int idx);
        return (idx == 0) ? 1 : 3;
    endfunction

    function automatic logic [31:0] exp_cnt(input int idx);
`ifdef RETIRE_CNT_EN
        return 32'(exp_retired[idx]);
`else
        return 32'(idx - idx);
`endif
    endfunction

    function automatic vec_t observe(input int i);
        vec_t o;
        o.st = state_dbg_s[i];        o.rst_dp = rst_dp_s[i];
        o.pc_wr = pc_wr_s[i];         o.pc_src = pc_src_s[i];
        o.ir_load = ir_load_s[i];     o.a_wr = a_wr_s[i];
        o.b_wr = b_wr_s[i];           o.alu_out_wr = alu_out_wr_s[i];
        o.alu_src_a = alu_src_a_s[i]; o.src_b = alu_src_b_s[i];
        o.sel = alu_sel_s[i];         o.imm = imm_type_s[i];
        o.mem_wr = mem_data_wr_s[i];  o.m2r = mem_to_reg_s[i];
        o.reg_wr = reg_wr_s[i];       o.halted = halted_s[i];
        return o;
    endfunction

    function automatic vec_t blank(input state_t s);
        vec_t e = '0;
        e.st = s;
        return e;
    endfunction

    // reference model: the expected per-cycle outputs of one whole instruction
    task automatic build(input kind_t k, input int m, input logic az);
        vec_t e;
        for (int i = 0; i < m; i++) begin
            e = blank(S_FETCH); e.src_b = SRC_B_FOUR; e.sel = ALU_ADD;
            if (i == m - 1) begin e.ir_load = 1'b1; e.pc_wr = 1'b1; end
            exp_q.push_back(e);
        end
        e = blank(S_DECODE); e.a_wr = 1'b1; e.b_wr = 1'b1; e.alu_out_wr = 1'b1;
        e.src_b = SRC_B_IMM; e.imm = IMM_B; e.sel = ALU_ADD;
        exp_q.push_back(e);
        case (k)
            K_ADD, K_SUB, K_ADDI: begin
                e = blank(k == K_ADDI ? S_EXEC_I : S_EXEC_R);
                e.alu_src_a = 1'b1; e.alu_out_wr = 1'b1;
                e.sel = (k == K_SUB) ? ALU_SUB : ALU_ADD;
                if (k == K_ADDI) begin e.src_b = SRC_B_IMM; e.imm = IMM_I; end
                exp_q.push_back(e);
                e = blank(S_WB_ALU); e.reg_wr = 1'b1;
                exp_q.push_back(e);
            end
            K_LD, K_SD: begin
                e = blank(S_ADDR); e.alu_src_a = 1'b1; e.src_b = SRC_B_IMM;
                e.imm = (k == K_SD) ? IMM_S : IMM_I; e.sel = ALU_ADD; e.alu_out_wr = 1'b1;
                exp_q.push_back(e);
                if (k == K_LD) begin
                    for (int i = 0; i < m; i++) exp_q.push_back(blank(S_MEM_RD));
                    e = blank(S_WB_MEM); e.reg_wr = 1'b1; e.m2r = 1'b1;
                    exp_q.push_back(e);
                end else begin
                    e = blank(S_MEM_WR); e.mem_wr = 1'b1;
                    exp_q.push_back(e);
                end
            end
            K_BEQ, K_BNE: begin
                e = blank(S_BRANCH); e.alu_src_a = 1'b1; e.sel = ALU_SUB; e.pc_src = 1'b1;
                e.pc_wr = (k == K_BEQ) ? az : !az;
                exp_q.push_back(e);
            end
            K_LUI: begin
                e = blank(S_LUI); e.src_b = SRC_B_IMM; e.imm = IMM_U;
                e.sel = ALU_PASS_B; e.reg_wr = 1'b1;
                exp_q.push_back(e);
            end
            default: begin
                e = blank(S_TRAP); e.halted = 1'b1;
                exp_q.push_back(e);
            end
        endcase
    endtask

    // driver tasks
    task automatic drive_enc(input int idx, input kind_t k, input logic az);
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = 3'($urandom_range(0, 7));
        f7 = 7'($urandom_range(0, 127));
        case (k)
            K_ADD:    begin op = OP_R; f3 = F3_ADD; f7 = F7_ADD; end
            K_SUB:    begin op = OP_R; f3 = F3_ADD; f7 = F7_SUB; end
            K_ADDI:   begin op = OP_IMM; f3 = F3_ADD; end
            K_LD:     begin op = OP_LOAD; f3 = F3_D; end
            K_SD:     begin op = OP_STORE; f3 = F3_D; end
            K_BEQ:    begin op = OP_BRANCH; f3 = F3_BEQ; end
            K_BNE:    begin op = OP_BRANCH; f3 = F3_BNE; end
            K_LUI:    op = OP_LUI;
            K_ILL_F7: begin op = OP_R; f3 = F3_ADD; f7 = 7'b0000001; end
            default:  op = 7'b1111111;
        endcase
        opcode[idx] = op; funct3[idx] = f3; funct7[idx] = f7; alu_zero[idx] = az;
    endtask

    task automatic do_reset(input int idx);
        rst[idx] = 1'b1;
        @(negedge clk);
        check($sformatf("d%0d reset", idx), observe(idx), blank(S_RESET) | 25'(1 << 19));
        @(negedge clk);
        exp_retired[idx] = 0;
        check($sformatf("d%0d reset_hold", idx), observe(idx), blank(S_RESET) | 25'(1 << 19));
        check($sformatf("d%0d reset_cnt", idx), retired_cnt_s[idx], exp_cnt(idx));
        rst[idx] = 1'b0;
        @(negedge clk);
    endtask

    // Entered at the negedge of the first FETCH cycle; leaves at the next one.
    task automatic run_instr(input int idx, input kind_t k, input logic az);
        int cyc = 0;
        drive_enc(idx, k, az);
        build(k, lat_of(idx), az);
        while (exp_q.size() > 0) begin
            check($sformatf("d%0d %s c%0d", idx, k.name(), cyc), observe(idx), exp_q.pop_front());
            cyc++;
            if (exp_q.size() > 0) @(negedge clk);
        end
        if (k != K_ILL && k != K_ILL_F7) begin
            @(negedge clk);
            exp_retired[idx]++;
            check($sformatf("d%0d %s retired", idx, k.name()), retired_cnt_s[idx], exp_cnt(idx));
        end
    endtask

    task automatic trap_test(input int idx, input kind_t k);
        run_instr(idx, k, 1'($urandom_range(0, 1)));
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            opcode[idx] = 7'($urandom_range(0, 127));
            alu_zero[idx] = 1'($urandom_range(0, 1));
            check($sformatf("d%0d trap_hold%0d", idx, i), observe(idx), blank(S_TRAP) | 25'(1));
        end
        check($sformatf("d%0d trap_cnt", idx), retired_cnt_s[idx], exp_cnt(idx));
        do_reset(idx);
    endtask

    // Reset lands at the end of EXEC_R: no writeback, counter cleared.
    task automatic abort_test(input int idx);
        int n;
        drive_enc(idx, K_ADD, 1'b0);
        build(K_ADD, lat_of(idx), 1'b0);
        n = exp_q.size() - 1;
        for (int i = 0; i < n; i++) begin
            check($sformatf("d%0d abort c%0d", idx, i), observe(idx), exp_q.pop_front());
            if (i < n - 1) @(negedge clk);
        end
        void'(exp_q.pop_front());
        rst[idx] = 1'b1;
        @(negedge clk);
        exp_retired[idx] = 0;
        check($sformatf("d%0d abort_rst", idx), observe(idx), blank(S_RESET) | 25'(1 << 19));
        check($sformatf("d%0d abort_cnt", idx), retired_cnt_s[idx], exp_cnt(idx));
        rst[idx] = 1'b0;
        @(negedge clk);
        check($sformatf("d%0d abort_fetch", idx), 32'(state_dbg_s[idx]), 32'(S_FETCH));
    endtask

    task automatic random_run(input int idx, input int n);
        kind_t k;
        for (int i = 0; i < n; i++) begin
            k = kind_t'($urandom_range(0, 7));
            run_instr(idx, k, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; opcode[i] = '0; funct3[i] = '0; funct7[i] = '0;
            alu_zero[i] = 1'b0; exp_retired[i] = 0;
        end
        // MEM_LAT = 1
        do_reset(0);
        run_instr(0, K_ADD, 1'b0);
        run_instr(0, K_SD, 1'b0);
        run_instr(0, K_LUI, 1'b0);
        trap_test(0, K_ILL);
        run_instr(0, K_BEQ, 1'b1);
        run_instr(0, K_BNE, 1'b1);
        run_instr(0, K_BEQ, 1'b0);
        random_run(0, 30);
        abort_test(0);
        rst[0] = 1'b1;
        // MEM_LAT = 3
        do_reset(1);
        run_instr(1, K_LD, 1'b0);
        random_run(1, 30);
        trap_test(1, K_ILL_F7);
        run_instr(1, K_SUB, 1'b1);
        abort_test(1);
        rst[1] = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
